// File: rtl/mux_share_arbiter.sv
// mux_share_arbiter: round-robin owner of a shared N:1 data mux with a registered output channel.
// Optional macro MUX_ARB_HOLD_LIMIT_EN caps a grant at MAX_HOLD cycles while others are waiting.
module mux_share_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned SEL_W    = 2,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] data_in,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [SEL_W-1:0]          sel,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    output logic                      busy
);
    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   r_ptr;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_out_valid;

    logic [NUM_REQ-1:0] w_cand;
    logic               w_found;
    logic [SEL_W-1:0]   w_win;
    logic [SEL_W-1:0]   w_ptr_next;
    int unsigned        w_idx;
    logic               w_owner_req;
    logic               w_force;
    logic               w_keep;
    logic               w_grant;
    logic [DATA_W-1:0]  w_slice [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign w_slice[g] = data_in[g*DATA_W +: DATA_W];
    end

    // The current owner is never a candidate, so a forced release always moves the grant elsewhere.
    assign w_cand      = req & ~r_gnt;
    assign w_owner_req = req[r_sel];

    // First candidate at or after the rotating pointer, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = (32'(r_ptr) + k) % NUM_REQ;
            if (!w_found && w_cand[SEL_W'(w_idx)]) begin
                w_found = 1'b1;
                w_win   = SEL_W'(w_idx);
            end
        end
    end

    assign w_ptr_next = (w_win == SEL_W'(NUM_REQ - 1)) ? '0 : w_win + SEL_W'(1);

`ifdef MUX_ARB_HOLD_LIMIT_EN
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] r_hold;

    assign w_force = (r_hold >= HOLD_W'(MAX_HOLD)) && w_found;

    // Consecutive-cycle count of the current grant; saturates while nobody else waits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
        end else if (w_grant) begin
            r_hold <= HOLD_W'(1);
        end else if (w_keep && (r_hold < HOLD_W'(MAX_HOLD))) begin
            r_hold <= r_hold + HOLD_W'(1);
        end
    end
`else
    // MAX_HOLD only matters when the hold limit is built in.
    assign w_force = (MAX_HOLD == 0) && 1'b0;
`endif

    assign w_keep  = (r_state == ST_BUSY) && w_owner_req && !w_force;
    assign w_grant = !w_keep && w_found;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_sel       <= '0;
            r_ptr       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_keep) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_slice[r_sel];
        end else if (w_grant) begin
            r_state     <= ST_BUSY;
            r_gnt       <= NUM_REQ'(1) << w_win;
            r_sel       <= w_win;
            r_ptr       <= w_ptr_next;
            r_out_valid <= 1'b1;
            r_out_data  <= w_slice[w_win];
        end else begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_out_valid <= 1'b0;
        end
    end

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign busy      = (r_state == ST_BUSY);

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Bench for mux_share_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_mux_share_arbiter;
    localparam int unsigned NUM_REQ  = 4;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned MAX_HOLD = 8;
`ifdef MUX_ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] data_in;
    logic [NUM_REQ-1:0]        gnt;
    logic [SEL_W-1:0]          sel;
    logic [DATA_W-1:0]         out_data;
    logic                      out_valid;
    logic                      busy;

    int checks   = 0;
    int failures = 0;

    // Model state: owner index or -1 when idle.
    int          m_owner;
    int          m_ptr;
    int          m_hold;
    int          m_sel;
    logic [7:0]  m_data;
    logic        m_valid;

    mux_share_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .SEL_W   (SEL_W),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .data_in  (data_in),
        .gnt      (gnt),
        .sel      (sel),
        .out_data (out_data),
        .out_valid(out_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] word_of(int i);
        return data_in[i*DATA_W +: DATA_W];
    endfunction

    // One rising edge of the arbiter, derived from the round-robin rules.
    function automatic void model_step();
        int others;
        bit keep;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_hold = 0; m_sel = 0; m_data = 8'h00; m_valid = 1'b0;
            return;
        end
        others = (m_owner >= 0) ? (int'(req) & ~(1 << m_owner)) : int'(req);
        keep = (m_owner >= 0) && req[m_owner];
        if (keep && HOLD_EN && (m_hold >= MAX_HOLD) && (others != 0)) keep = 1'b0;
        if (keep) begin
            if (m_hold < MAX_HOLD) m_hold++;
            m_data  = word_of(m_owner);
            m_valid = 1'b1;
        end else if (others != 0) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (others[(m_ptr + k) % NUM_REQ]) begin
                    m_owner = (m_ptr + k) % NUM_REQ;
                    break;
                end
            end
            m_ptr   = (m_owner + 1) % NUM_REQ;
            m_sel   = m_owner;
            m_hold  = 1;
            m_data  = word_of(m_owner);
            m_valid = 1'b1;
        end else begin
            m_owner = -1;
            m_valid = 1'b0;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [31:0] exp_gnt;
        model_step();
        @(posedge clk);
        #1;
        exp_gnt = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        check("gnt", 32'(gnt), exp_gnt);
        check("sel", 32'(sel), 32'(m_sel));
        check("busy", 32'(busy), 32'(m_owner >= 0));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data", 32'(out_data), 32'(m_data));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'($urandom);
        data_in = $urandom;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_order;
        rst = 1'b1;
        req = 4'($urandom);
        data_in = $urandom;

        // Reset for two cycles with random requests.
        tick();
        req = 4'($urandom);
        tick();
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);

        // Single requester 2 for three cycles.
        rst = 1'b0;
        req = 4'b0100;
        data_in = $urandom;
        data_in[2*DATA_W +: DATA_W] = 8'hA5;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("single_gnt", 32'(gnt), 32'h4);
            check("single_sel", 32'(sel), 32'd2);
            check("single_data", 32'(out_data), 32'hA5);
        end
        req = 4'b0000;
        tick();
        check("single_idle", 32'(busy), 32'd0);

        // Contention from reset: 1 wins, then 3 takes over with no bubble.
        do_reset();
        req = 4'b1010;
        data_in = $urandom;
        tick();
        check("contend_first", 32'(gnt), 32'h2);
        tick();
        req = 4'b1000;
        tick();
        check("contend_handoff", 32'(gnt), 32'h8);
        check("contend_busy", 32'(busy), 32'd1);

        // Rotation: everyone requesting, each owner drops after one cycle.
        do_reset();
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            data_in = $urandom;
            tick();
            exp_order = 4'(1 << (n % NUM_REQ));
            check("rotate_gnt", 32'(gnt), 32'(exp_order));
            req = 4'b1111 & ~gnt;
        end

        // Hold limit: requester 0 never drops while requester 1 waits.
        do_reset();
        req = 4'b0011;
        for (int c = 1; c <= 12; c++) begin
            data_in = $urandom;
            tick();
            if (c <= MAX_HOLD) check("hold_owner", 32'(gnt), 32'h1);
            else check("hold_after", 32'(gnt), HOLD_EN ? 32'h2 : 32'h1);
        end

        // Reset in the third cycle of a grant to requester 3.
        do_reset();
        req = 4'b1000;
        tick();
        tick();
        tick();
        check("midburst_gnt", 32'(gnt), 32'h8);
        rst = 1'b1;
        tick();
        check("midburst_gnt0", 32'(gnt), 32'd0);
        check("midburst_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        req = 4'b1001;
        tick();
        check("midburst_restart", 32'(gnt), 32'h1);

        // Random traffic with sticky requests and occasional resets.
        for (int c = 0; c < 400; c++) begin
            data_in = $urandom;
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            else if ($urandom_range(0, 4) == 0) req = req & 4'($urandom);
            rst = ($urandom_range(0, 59) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
